// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute-to-memory inputs and memory-to-writeback outputs of mem_stage
interface mem_stage_if;
    logic        ValidE;
    logic        RegWriteE;
    logic        MemtoRegE;
    logic        MemWriteE;
    logic [4:0]  WriteRegE;
    logic [31:0] ALUOutE;
    logic [31:0] WriteDataE;
    logic        StallM;
    logic        ValidW;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;

    modport master (
        output ValidE, RegWriteE, MemtoRegE, MemWriteE, WriteRegE, ALUOutE, WriteDataE,
        input  StallM, ValidW, RegWriteW, WriteRegW, ResultW
    );

    modport slave (
        input  ValidE, RegWriteE, MemtoRegE, MemWriteE, WriteRegE, ALUOutE, WriteDataE,
        output StallM, ValidW, RegWriteW, WriteRegW, ResultW
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: EX/MEM register, latency-counted data RAM access, MEM/WB register
module mem_stage #(
    parameter int MEM_WORDS   = 512,
    parameter int MEM_LATENCY = 2
) (
    input  logic       CLK,
    input  logic       RSTn,
    mem_stage_if.slave bus
);
    localparam int ADDR_BITS = $clog2(MEM_WORDS);
    localparam int CNT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_m_q, valid_m_d;
    logic              regwrite_m_q, regwrite_m_d;
    logic              memtoreg_m_q, memtoreg_m_d;
    logic              memwrite_m_q, memwrite_m_d;
    logic [4:0]        writereg_m_q, writereg_m_d;
    logic [31:0]       aluout_m_q, aluout_m_d;
    logic [31:0]       writedata_m_q, writedata_m_d;
    logic              valid_w_q, valid_w_d;
    logic              regwrite_w_q, regwrite_w_d;
    logic [4:0]        writereg_w_q, writereg_w_d;
    logic [31:0]       result_w_q, result_w_d;

    logic [31:0]          ram [MEM_WORDS];
    logic [ADDR_BITS-1:0] ram_idx;
    logic [31:0]          ram_rdata;
    logic                 ram_we;
    logic                 stall;
    logic                 complete;
    logic                 mem_op_e;

    // Byte-offset bits and bits above the RAM size are dropped, so addresses wrap.
    assign ram_idx   = aluout_m_q[ADDR_BITS+1:2];
    assign ram_rdata = ram[ram_idx];
    assign stall     = valid_m_q & (memtoreg_m_q | memwrite_m_q) & (cnt_q != '0);
    assign complete  = valid_m_q & (cnt_q == '0);
    assign ram_we    = complete & memwrite_m_q;
    assign mem_op_e  = bus.ValidE & (bus.MemtoRegE | bus.MemWriteE);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        valid_m_d     = valid_m_q;
        regwrite_m_d  = regwrite_m_q;
        memtoreg_m_d  = memtoreg_m_q;
        memwrite_m_d  = memwrite_m_q;
        writereg_m_d  = writereg_m_q;
        aluout_m_d    = aluout_m_q;
        writedata_m_d = writedata_m_q;
        valid_w_d     = 1'b0;
        regwrite_w_d  = 1'b0;
        writereg_w_d  = writereg_w_q;
        result_w_d    = result_w_q;

        if (!stall) begin
            valid_m_d     = bus.ValidE;
            regwrite_m_d  = bus.RegWriteE;
            memtoreg_m_d  = bus.MemtoRegE;
            memwrite_m_d  = bus.MemWriteE;
            writereg_m_d  = bus.WriteRegE;
            aluout_m_d    = bus.ALUOutE;
            writedata_m_d = bus.WriteDataE;
        end

        case (state_q)
            IDLE: begin
                if (!stall && mem_op_e && (MEM_LATENCY > 1)) begin
                    cnt_d   = LAT_M1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Read data is sampled before the same-edge store lands: read-before-write.
        if (complete) begin
            valid_w_d    = 1'b1;
            regwrite_w_d = regwrite_m_q;
            writereg_w_d = writereg_m_q;
            result_w_d   = memtoreg_m_q ? ram_rdata : aluout_m_q;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            valid_m_q     <= 1'b0;
            regwrite_m_q  <= 1'b0;
            memtoreg_m_q  <= 1'b0;
            memwrite_m_q  <= 1'b0;
            writereg_m_q  <= '0;
            aluout_m_q    <= '0;
            writedata_m_q <= '0;
            valid_w_q     <= 1'b0;
            regwrite_w_q  <= 1'b0;
            writereg_w_q  <= '0;
            result_w_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            valid_m_q     <= valid_m_d;
            regwrite_m_q  <= regwrite_m_d;
            memtoreg_m_q  <= memtoreg_m_d;
            memwrite_m_q  <= memwrite_m_d;
            writereg_m_q  <= writereg_m_d;
            aluout_m_q    <= aluout_m_d;
            writedata_m_q <= writedata_m_d;
            valid_w_q     <= valid_w_d;
            regwrite_w_q  <= regwrite_w_d;
            writereg_w_q  <= writereg_w_d;
            result_w_q    <= result_w_d;
        end
    end

    // RAM has no reset; a store still pending at reset is dropped because valid_m_q clears.
    always_ff @(posedge CLK) begin
        if (ram_we) ram[ram_idx] <= writedata_m_q;
    end

    assign bus.StallM    = stall;
    assign bus.ValidW    = valid_w_q;
    assign bus.RegWriteW = regwrite_w_q;
    assign bus.WriteRegW = writereg_w_q;
    assign bus.ResultW   = result_w_q;
endmodule
